// File: rtl/mitchell_div.sv
// Three-stage pipelined approximate unsigned divider using Mitchell's logarithm method.
// Optional build macro MITCHELL_DIV_ROUND_EN: round-to-nearest on right shifts instead of truncation.
module mitchell_div #(
  parameter int W    = 8,
  parameter int FRAC = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [W-1:0]      a,
  input  logic [W-1:0]      b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [W+FRAC-1:0] q,
  output logic              div_by_zero
);

  localparam int KW = $clog2(W);
  localparam int EW = KW + 2;
  localparam int QW = W + FRAC;

  function automatic logic [KW-1:0] msb_idx(input logic [W-1:0] v);
    logic [KW-1:0] k;
    k = '0;
    for (int i = 0; i < W; i++)
      if (v[i]) k = KW'(i);
    return k;
  endfunction

  function automatic logic [W-2:0] frac_of(input logic [W-1:0] v, input logic [KW-1:0] k);
    logic [W-1:0] sh;
    sh = W'(KW'(W - 1) - k);
    return (W-1)'(v << sh);
  endfunction

  logic              adv;
  logic              v1, v2;
  logic              az1, bz1, az2, bz2;
  logic [KW-1:0]     ka1, kb1;
  logic [W-2:0]      xa1, xb1;
  logic [W-1:0]      m2;
  logic signed [EW-1:0] e2;

  logic [KW-1:0]     ka_n, kb_n;
  logic              ge;
  logic [W-1:0]      diff, m_n;
  logic [EW-1:0]     e_n;
  int                s;
  logic [QW-1:0]     wide, q_shift, q_n;
  logic              dz_n;
`ifdef MITCHELL_DIV_ROUND_EN
  logic [QW-1:0]     rnd_tmp;
`endif

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  always_comb begin
    ka_n = msb_idx(a);
    kb_n = msb_idx(b);
  end

  // Log subtract; when xa < xb the W-bit wrap of the difference already equals 2 + xa - xb.
  always_comb begin
    ge   = (xa1 >= xb1);
    diff = {1'b0, xa1} - {1'b0, xb1};
    m_n  = ge ? {1'b1, diff[W-2:0]} : diff;
    e_n  = EW'({2'b00, ka1}) - EW'({2'b00, kb1}) - EW'(!ge);
  end

  always_comb begin
    s    = int'(e2) + FRAC - (W - 1);
    wide = {{FRAC{1'b0}}, m2};
    if (s >= 0) begin
      q_shift = wide << s;
    end else begin
      q_shift = wide >> (-s);
`ifdef MITCHELL_DIV_ROUND_EN
      rnd_tmp = wide >> (-s - 1);
      q_shift = q_shift + {{(QW-1){1'b0}}, rnd_tmp[0]};
`endif
    end
`ifdef MITCHELL_DIV_ROUND_EN
    if (s >= 0) rnd_tmp = '0;
`endif
    if (bz2) begin
      q_n  = '1;
      dz_n = 1'b1;
    end else if (az2) begin
      q_n  = '0;
      dz_n = 1'b0;
    end else begin
      q_n  = q_shift;
      dz_n = 1'b0;
    end
  end

  // All three stages advance together; a stalled output freezes the whole pipe.
  always_ff @(posedge clk) begin
    if (rst) begin
      v1          <= 1'b0;
      v2          <= 1'b0;
      out_valid   <= 1'b0;
      az1         <= 1'b0;
      bz1         <= 1'b0;
      ka1         <= '0;
      kb1         <= '0;
      xa1         <= '0;
      xb1         <= '0;
      az2         <= 1'b0;
      bz2         <= 1'b0;
      m2          <= '0;
      e2          <= '0;
      q           <= '0;
      div_by_zero <= 1'b0;
    end else if (adv) begin
      v1          <= in_valid;
      az1         <= (a == '0);
      bz1         <= (b == '0);
      ka1         <= ka_n;
      kb1         <= kb_n;
      xa1         <= frac_of(a, ka_n);
      xb1         <= frac_of(b, kb_n);
      v2          <= v1;
      az2         <= az1;
      bz2         <= bz1;
      m2          <= m_n;
      e2          <= e_n;
      out_valid   <= v2;
      q           <= q_n;
      div_by_zero <= dz_n;
    end
  end

endmodule

// File: tb/tb_mitchell_div.sv
// Randomised and directed self-checking bench for mitchell_div against a log-domain reference model.
module tb_mitchell_div;

  localparam int W    = 8;
  localparam int FRAC = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [W-1:0]      a;
  logic [W-1:0]      b;
  logic              out_valid;
  logic              out_ready;
  logic [W+FRAC-1:0] q;
  logic              div_by_zero;

  always #5 clk = ~clk;

  mitchell_div #(.W(W), .FRAC(FRAC)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .q(q), .div_by_zero(div_by_zero)
  );

  typedef struct {
    logic [16:0] exp;
    int          cyc;
    bit          seen;
  } entry_t;

  entry_t      sb[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  bit          strict_lat;
  bit          use_table;
  logic [16:0] cur_exp;
  logic [7:0]  stim_a[$];
  logic [7:0]  stim_b[$];
  logic [16:0] stim_e[$];

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int flog2(input logic [7:0] v);
    int k;
    k = 0;
    for (int i = 0; i < 8; i++)
      if (v[i]) k = i;
    return k;
  endfunction

  // Mitchell: log2(v) ~ k + (v/2^k - 1), kept as a fixed-point value with 7 fractional bits.
  function automatic logic [16:0] model(input logic [7:0] av, input logic [7:0] bv);
    int     ka, kb, la, lb, d, e, f;
    longint t, res;
    if (bv == 0) return 17'h1FFFF;
    if (av == 0) return 17'h00000;
    ka = flog2(av);
    kb = flog2(bv);
    la = ka * 128 + ((int'(av) * 128) >> ka) - 128;
    lb = kb * 128 + ((int'(bv) * 128) >> kb) - 128;
    d  = la - lb;
    e  = d >>> 7;
    f  = d - e * 128;
    t  = longint'(128 + f) << (20 + e + 1);
`ifdef MITCHELL_DIV_ROUND_EN
    res = (t + (longint'(1) << 19)) >> 20;
`else
    res = t >> 20;
`endif
    return {1'b0, res[15:0]};
  endfunction

  task automatic step();
    bit acc, del;
    entry_t ent;
    #1;
    acc = in_valid && in_ready && !rst;
    del = out_valid && out_ready && !rst;
    @(posedge clk);
    #1;
    cyc++;
    if (rst) begin
      sb.delete();
    end else begin
      if (del && sb.size() > 0) void'(sb.pop_front());
      if (acc) begin
        ent.exp  = cur_exp;
        ent.cyc  = cyc - 1;
        ent.seen = 1'b0;
        sb.push_back(ent);
      end
      checkOutput("in_ready", in_ready, !(out_valid && !out_ready));
      if (out_valid) begin
        if (sb.size() == 0) begin
          checkOutput("spurious_valid", out_valid, 0);
        end else begin
          checkOutput("result", {div_by_zero, q}, sb[0].exp);
          if (!sb[0].seen) begin
            sb[0].seen = 1'b1;
            if (strict_lat) checkOutput("latency", cyc - sb[0].cyc, 3);
          end
        end
      end
    end
  endtask

  task automatic applyStimulus(input int n, input int stall_start, input int stall_len, input bit rand_mode);
    int idx, t, budget;
    bit accepted;
    idx    = 0;
    t      = 0;
    budget = n * 10 + 50;
    in_valid = 1'b0;
    while ((idx < n || sb.size() > 0) && t < budget) begin
      if (rand_mode) out_ready = ($urandom_range(0, 3) != 0);
      else           out_ready = !(t >= stall_start && t < stall_start + stall_len);
      if (idx < n) begin
        if (!in_valid) in_valid = rand_mode ? ($urandom_range(0, 3) != 0) : 1'b1;
        a       = stim_a[idx];
        b       = stim_b[idx];
        cur_exp = use_table ? stim_e[idx] : model(stim_a[idx], stim_b[idx]);
      end else begin
        in_valid = 1'b0;
      end
      #0;
      accepted = in_valid && in_ready;
      step();
      if (accepted) begin
        idx++;
        in_valid = 1'b0;
      end
      t++;
    end
    if (t >= budget) checkOutput("timeout", sb.size() + n - idx, 0);
    in_valid  = 1'b0;
    out_ready = 1'b1;
  endtask

  task automatic addVec(input logic [7:0] av, input logic [7:0] bv, input logic [16:0] ev);
    stim_a.push_back(av);
    stim_b.push_back(bv);
    stim_e.push_back(ev);
  endtask

  task automatic clearVecs();
    stim_a.delete();
    stim_b.delete();
    stim_e.delete();
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0;
    cur_exp = '0; strict_lat = 1'b0; use_table = 1'b0;
    repeat (3) step();
    rst = 1'b0;
    #1;
    checkOutput("reset_out_valid", out_valid, 0);
    checkOutput("reset_q", q, 0);
    checkOutput("reset_dz", div_by_zero, 0);
    checkOutput("reset_in_ready", in_ready, 1);

    // Directed corner cases with spec-given results, streamed back-to-back
    clearVecs();
    addVec(8'd8,   8'd2,   17'h00400);
    addVec(8'd15,  8'd5,   17'h00340);
    addVec(8'd5,   8'd3,   17'h001C0);
    addVec(8'd255, 8'd1,   17'h0FF00);
    addVec(8'd1,   8'd255, 17'h00001);
`ifdef MITCHELL_DIV_ROUND_EN
    addVec(8'd7,   8'd200, 17'h0000A);
`else
    addVec(8'd7,   8'd200, 17'h00009);
`endif
    addVec(8'd7,   8'd0,   17'h1FFFF);
    addVec(8'd0,   8'd0,   17'h1FFFF);
    addVec(8'd0,   8'd9,   17'h00000);
    use_table  = 1'b1;
    strict_lat = 1'b1;
    applyStimulus(stim_a.size(), 1000, 0, 1'b0);

    // Six pairs with a four-cycle output stall once the pipe has filled
    clearVecs();
    for (int i = 0; i < 6; i++) addVec(8'($urandom_range(1, 255)), 8'($urandom_range(1, 255)), '0);
    use_table  = 1'b0;
    strict_lat = 1'b0;
    applyStimulus(6, 3, 4, 1'b0);

    // Reset with two results in flight
    in_valid = 1'b1; a = 8'd100; b = 8'd3; cur_exp = model(8'd100, 8'd3);
    step();
    a = 8'd9; b = 8'd4; cur_exp = model(8'd9, 8'd4);
    step();
    in_valid = 1'b0; rst = 1'b1;
    step();
    rst = 1'b0;
    checkOutput("rst_out_valid", out_valid, 0);
    repeat (6) step();
    clearVecs();
    addVec(8'd200, 8'd7, '0);
    strict_lat = 1'b1;
    applyStimulus(1, 1000, 0, 1'b0);

    // Random operands with random valid gaps and backpressure
    clearVecs();
    for (int i = 0; i < 300; i++) begin
      addVec(($urandom_range(0, 9) == 0) ? 8'd0 : 8'($urandom),
             ($urandom_range(0, 9) == 0) ? 8'd0 : 8'($urandom), '0);
    end
    strict_lat = 1'b0;
    applyStimulus(300, 0, 0, 1'b1);

    repeat (4) step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
